// File: rtl/lead_lag_pkg.sv
// Shared constants for the lead/lag loop filter: mode encoding and reset defaults.
package lead_lag_pkg;

  localparam int unsigned LLF_MODE_LEAKY = 0;
  localparam int unsigned LLF_MODE_WALK  = 1;

  localparam int unsigned LLF_C_DEF   = 1;
  localparam int unsigned LLF_D_DEF   = 1;
  localparam int unsigned LLF_MAX_DEF = 1000;

endpackage

// File: rtl/lead_lag_chan.sv
// One leaky saturating counter: adds C on input, leaks D while at or above D, clamps to 0..MAX.
module lead_lag_chan
  import lead_lag_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic [CNT_W-1:0] c,
  input  logic [CNT_W-1:0] d,
  input  logic [CNT_W-1:0] max_cur,
  input  logic             cfg_upd,
  input  logic [CNT_W-1:0] max_new,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam int unsigned SW = CNT_W + 2;

  logic signed [SW-1:0] cnt_s, inc_s, dec_s, lim_s, new_s, nxt_s;
  logic [CNT_W-1:0]     cnt_d, max_eff;
  logic                 at_max_d;

  // Step with the current gains/limit, then clamp to a freshly written limit.
  always_comb begin
    cnt_s    = signed'(SW'(cnt));
    inc_s    = inc ? signed'(SW'(c)) : '0;
    dec_s    = (cnt >= d) ? signed'(SW'(d)) : '0;
    lim_s    = signed'(SW'(max_cur));
    new_s    = signed'(SW'(max_new));
    nxt_s    = cnt_s;
    if (en) begin
      nxt_s = cnt_s + inc_s - dec_s;
      if (nxt_s[SW-1]) nxt_s = '0;
      if (nxt_s > lim_s) nxt_s = lim_s;
    end
    if (cfg_upd && (nxt_s > new_s)) nxt_s = new_s;
    max_eff  = cfg_upd ? max_new : max_cur;
    cnt_d    = CNT_W'(nxt_s);
    at_max_d = (cnt_d == max_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      at_max <= at_max_d;
    end
  end

endmodule

// File: rtl/lead_lag_filter.sv
// Lead/lag loop filter for a digital PLL: turns phase-detector lead/lag hits into
// DCO add/sub correction pulses, either via two leaky accumulators or a signed random walk.
module lead_lag_filter
  import lead_lag_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_DEF = LLF_MAX_DEF,
  parameter int unsigned C_DEF   = LLF_C_DEF,
  parameter int unsigned D_DEF   = LLF_D_DEF,
  parameter int unsigned MODE    = LLF_MODE_LEAKY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             lead,
  input  logic             lag,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_c,
  input  logic [CNT_W-1:0] cfg_d,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             cfg_err,
  output logic             add_pulse,
  output logic             sub_pulse,
  output logic [CNT_W-1:0] lead_cnt,
  output logic [CNT_W-1:0] lag_cnt,
  output logic             sat
);

  localparam int unsigned SW = CNT_W + 2;

  logic [CNT_W-1:0] c_q, d_q, max_q;
  logic             cfg_ok_c, cfg_upd_c;
  logic             lead_e, lag_e;
  logic             add_raw, sub_raw;

  // Simultaneous lead and lag carry no phase information.
  assign lead_e = lead & ~lag;
  assign lag_e  = lag & ~lead;

  // MAX must stay positive and fit a signed CNT_W value so -MAX is representable.
  assign cfg_ok_c  = (cfg_c != '0) && (cfg_d != '0) && (cfg_max != '0) && !cfg_max[CNT_W-1];
  assign cfg_upd_c = cfg_we & cfg_ok_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= CNT_W'(C_DEF);
      d_q     <= CNT_W'(D_DEF);
      max_q   <= CNT_W'(MAX_DEF);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok_c;
      if (cfg_upd_c) begin
        c_q   <= cfg_c;
        d_q   <= cfg_d;
        max_q <= cfg_max;
      end
    end
  end

  // Opposing requests in the same cycle cancel rather than fight in the DCO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_pulse <= 1'b0;
      sub_pulse <= 1'b0;
    end else begin
      add_pulse <= add_raw & ~sub_raw;
      sub_pulse <= sub_raw & ~add_raw;
    end
  end

  if (MODE == LLF_MODE_LEAKY) begin : g_leaky
    logic lead_at_max, lag_at_max;

    lead_lag_chan #(.CNT_W(CNT_W)) u_lead_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .inc     (lead_e),
      .c       (c_q),
      .d       (d_q),
      .max_cur (max_q),
      .cfg_upd (cfg_upd_c),
      .max_new (cfg_max),
      .cnt     (lead_cnt),
      .at_max  (lead_at_max)
    );

    lead_lag_chan #(.CNT_W(CNT_W)) u_lag_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .inc     (lag_e),
      .c       (c_q),
      .d       (d_q),
      .max_cur (max_q),
      .cfg_upd (cfg_upd_c),
      .max_new (cfg_max),
      .cnt     (lag_cnt),
      .at_max  (lag_at_max)
    );

    assign sat     = lead_at_max | lag_at_max;
    assign add_raw = en & (lead_cnt >= d_q);
    assign sub_raw = en & (lag_cnt >= d_q);
  end else begin : g_walk
    logic signed [CNT_W-1:0] walk_q;
    logic                    walk_sat_q;
    logic signed [SW-1:0]    walk_s, c_s, sum_s, lim_s, new_s, eff_s, nxt_s;
    logic                    walk_add_c, walk_sub_c;
    logic                    unused_walk;

    // D only shapes the leaky channels.
    assign unused_walk = ^d_q;

    // Walk by +/-C; crossing +/-MAX fires a correction and recentres the walk.
    always_comb begin
      walk_s     = SW'(walk_q);
      c_s        = signed'(SW'(c_q));
      lim_s      = signed'(SW'(max_q));
      new_s      = signed'(SW'(cfg_max));
      eff_s      = cfg_upd_c ? new_s : lim_s;
      sum_s      = walk_s;
      nxt_s      = walk_s;
      walk_add_c = 1'b0;
      walk_sub_c = 1'b0;
      if (lead_e)     sum_s = walk_s + c_s;
      else if (lag_e) sum_s = walk_s - c_s;
      if (en && (lead_e || lag_e)) begin
        if (sum_s >= lim_s) begin
          nxt_s      = '0;
          walk_add_c = 1'b1;
        end else if (sum_s <= -lim_s) begin
          nxt_s      = '0;
          walk_sub_c = 1'b1;
        end else begin
          nxt_s = sum_s;
        end
      end
      if (cfg_upd_c) begin
        if (nxt_s > new_s)       nxt_s = new_s;
        else if (nxt_s < -new_s) nxt_s = -new_s;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        walk_q     <= '0;
        walk_sat_q <= 1'b0;
      end else begin
        walk_q     <= CNT_W'(nxt_s);
        walk_sat_q <= (nxt_s == eff_s) || (nxt_s == -eff_s);
      end
    end

    assign lead_cnt = walk_q;
    assign lag_cnt  = '0;
    assign sat      = walk_sat_q;
    assign add_raw  = walk_add_c;
    assign sub_raw  = walk_sub_c;
  end

endmodule

// File: tb/tb_lead_lag_filter.sv
// Directed bench for lead_lag_filter: one leaky-mode and one walk-mode instance share stimulus.
module tb_lead_lag_filter;

  logic        clk = 1'b0;
  logic        rst_n, en, lead, lag, cfg_we;
  logic [15:0] cfg_c, cfg_d, cfg_max;

  logic        e0_err, e0_add, e0_sub, e0_sat;
  logic [15:0] e0_lcnt, e0_gcnt;
  logic        w1_err, w1_add, w1_sub, w1_sat;
  logic [15:0] w1_lcnt, w1_gcnt;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned c_lcnt[6] = '{5, 9, 13, 17, 20, 20};
  int unsigned c_sat[6]  = '{0, 0, 0, 0, 1, 1};
  int unsigned c_wcnt[6] = '{5, 10, 15, 0, 5, 10};
  int unsigned c_wadd[6] = '{0, 0, 0, 1, 0, 0};
  int unsigned bad_c[4]  = '{2, 0, 2, 2};
  int unsigned bad_d[4]  = '{0, 1, 1, 1};
  int unsigned bad_m[4]  = '{30, 30, 0, 32768};
  int unsigned e_wcnt[4] = '{1, 2, 3, 0};
  int unsigned e_wadd[4] = '{0, 0, 0, 1};

  always #5 clk = ~clk;

  lead_lag_filter #(.CNT_W(16), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .lead(lead), .lag(lag),
    .cfg_we(cfg_we), .cfg_c(cfg_c), .cfg_d(cfg_d), .cfg_max(cfg_max),
    .cfg_err(e0_err), .add_pulse(e0_add), .sub_pulse(e0_sub),
    .lead_cnt(e0_lcnt), .lag_cnt(e0_gcnt), .sat(e0_sat)
  );

  lead_lag_filter #(.CNT_W(16), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .lead(lead), .lag(lag),
    .cfg_we(cfg_we), .cfg_c(cfg_c), .cfg_d(cfg_d), .cfg_max(cfg_max),
    .cfg_err(w1_err), .add_pulse(w1_add), .sub_pulse(w1_sub),
    .lead_cnt(w1_lcnt), .lag_cnt(w1_gcnt), .sat(w1_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int unsigned c, input int unsigned d, input int unsigned m);
    cfg_c   = 16'(c);
    cfg_d   = 16'(d);
    cfg_max = 16'(m);
    cfg_we  = 1'b1;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    lead  = 1'b0;
    lag   = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lead = 1'b0; lag = 1'b0;
    cfg_we = 1'b0; cfg_c = '0; cfg_d = '0; cfg_max = '0;
    #3;
    chk("rst_lcnt", 32'(e0_lcnt), 0);
    chk("rst_gcnt", 32'(e0_gcnt), 0);
    chk("rst_pulses", 32'({e0_add, e0_sub, e0_sat, e0_err}), 0);
    chk("rst_walk", 32'(w1_lcnt), 0);
    step();
    rst_n = 1'b1;
    en    = 1'b1;

    // Defaults, short lead burst.
    lead = 1'b1;
    step(); chk("a_cnt1", 32'(e0_lcnt), 1); chk("a_add1", 32'(e0_add), 0);
    step(); chk("a_cnt2", 32'(e0_lcnt), 1); chk("a_add2", 32'(e0_add), 1);
    step(); chk("a_cnt3", 32'(e0_lcnt), 1);
    lead = 1'b0;
    step(); chk("a_cnt4", 32'(e0_lcnt), 0); chk("a_add4", 32'(e0_add), 1);
    step(); chk("a_cnt5", 32'(e0_lcnt), 0); chk("a_add5", 32'(e0_add), 0);
    chk("a_walk", 32'(w1_lcnt), 3);
    chk("a_walk_lag", 32'(w1_gcnt), 0);

    // Cancel: both asserted leaves everything frozen.
    lead = 1'b1; lag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("b_cnts", 32'({e0_lcnt, e0_gcnt}), 0);
      chk("b_pulses", 32'({e0_add, e0_sub, w1_add, w1_sub}), 0);
      chk("b_walk", 32'(w1_lcnt), 3);
    end
    lead = 1'b0;
    step(); chk("b_gcnt1", 32'(e0_gcnt), 1); chk("b_sub1", 32'(e0_sub), 0); chk("b_walk1", 32'(w1_lcnt), 2);
    step(); chk("b_gcnt2", 32'(e0_gcnt), 1); chk("b_sub2", 32'(e0_sub), 1); chk("b_walk2", 32'(w1_lcnt), 1);
    lag = 1'b0;

    // C=5 D=1 MAX=20: leaky saturates, walk wraps to 0 with a pulse.
    do_reset();
    cfg_write(5, 1, 20);
    chk("c_cfg_ok", 32'(e0_err), 0);
    en = 1'b1; lead = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("c_lcnt", 32'(e0_lcnt), c_lcnt[i]);
      chk("c_sat", 32'(e0_sat), c_sat[i]);
      chk("c_walk", 32'(w1_lcnt), c_wcnt[i]);
      chk("c_wadd", 32'(w1_add), c_wadd[i]);
    end

    // Rejected writes leave C/D/MAX alone.
    en = 1'b0; lead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_write(bad_c[i], bad_d[i], bad_m[i]);
      chk("d_cfg_err", 32'(e0_err), 1);
    end
    step();
    chk("d_err_clr", 32'(e0_err), 0);
    chk("d_hold", 32'(e0_lcnt), 20);
    chk("d_hold_pulse", 32'(e0_add), 0);
    en = 1'b1; lead = 1'b1;
    step();
    chk("d_old_max", 32'(e0_lcnt), 20);
    chk("d_old_c", 32'(w1_lcnt), 15);
    en = 1'b0; lead = 1'b0;
    cfg_write(1, 1, 3);
    chk("d_clamp", 32'(e0_lcnt), 3);
    chk("d_clamp_sat", 32'(e0_sat), 1);
    chk("d_wclamp", 32'(w1_lcnt), 3);
    chk("d_wclamp_sat", 32'(w1_sat), 1);
    chk("d_valid_err", 32'(e0_err), 0);

    // Walk C=1 MAX=4, then a write in a counting cycle uses the old C.
    do_reset();
    cfg_write(1, 1, 4);
    en = 1'b1; lead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("e_walk", 32'(w1_lcnt), e_wcnt[i]);
      chk("e_wadd", 32'(w1_add), e_wadd[i]);
    end
    cfg_c = 16'd3; cfg_d = 16'd1; cfg_max = 16'd100; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("e_same_cyc", 32'(w1_lcnt), 1);
    chk("e_wadd_off", 32'(w1_add), 0);
    step();
    chk("e_new_c", 32'(w1_lcnt), 4);
    lead = 1'b0;

    // Both leaky channels over D at once: pulses suppressed.
    do_reset();
    cfg_write(3, 1, 100);
    en = 1'b1; lead = 1'b1;
    step(); chk("f_lcnt1", 32'(e0_lcnt), 3); chk("f_add1", 32'(e0_add), 0);
    lead = 1'b0; lag = 1'b1;
    step();
    chk("f_lcnt2", 32'(e0_lcnt), 2); chk("f_gcnt2", 32'(e0_gcnt), 3);
    chk("f_add2", 32'(e0_add), 1); chk("f_sub2", 32'(e0_sub), 0);
    lag = 1'b0;
    step();
    chk("f_lcnt3", 32'(e0_lcnt), 1); chk("f_gcnt3", 32'(e0_gcnt), 2);
    chk("f_both_off", 32'({e0_add, e0_sub}), 0);

    // Reset mid-operation with a pulse active and a custom config.
    do_reset();
    cfg_write(3, 2, 50);
    en = 1'b1; lead = 1'b1;
    step(); chk("g_lcnt1", 32'(e0_lcnt), 3); chk("g_add1", 32'(e0_add), 0);
    step(); chk("g_lcnt2", 32'(e0_lcnt), 4); chk("g_add2", 32'(e0_add), 1);
    chk("g_walk2", 32'(w1_lcnt), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("g_rst_lcnt", 32'(e0_lcnt), 0);
    chk("g_rst_add", 32'(e0_add), 0);
    chk("g_rst_walk", 32'(w1_lcnt), 0);
    chk("g_rst_sat", 32'({e0_sat, w1_sat}), 0);
    step();
    rst_n = 1'b1;
    step(); chk("g_first", 32'(e0_lcnt), 1); chk("g_wfirst", 32'(w1_lcnt), 1);
    step(); chk("g_def_d", 32'(e0_lcnt), 1); chk("g_def_add", 32'(e0_add), 1);
    en = 1'b0;
    step();
    chk("g_en_hold", 32'(e0_lcnt), 1);
    chk("g_en_add", 32'(e0_add), 0);
    chk("g_en_walk", 32'(w1_lcnt), 2);
    lead = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lead_lag_filter.md
LEAD_LAG_FILTER -- requirements
Module: lead_lag_filter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: counter and config width.
REQ-002 The block SHALL have parameter MAX_DEF, default 1000: reset value of the saturation limit.
REQ-003 The block SHALL have parameter C_DEF, default 1: reset value of the increment gain.
REQ-004 The block SHALL have parameter D_DEF, default 1: reset value of the decrement gain and pulse threshold.
REQ-005 The block SHALL have parameter MODE, default 0: 0 = dual leaky accumulators, 1 = signed random-walk.
REQ-006 The block SHALL have port clk, input, 1 bit: clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port en, input, 1 bit: count enable.
REQ-009 The block SHALL have port lead, input, 1 bit: phase-detector lead indication.
REQ-010 The block SHALL have port lag, input, 1 bit: phase-detector lag indication.
REQ-011 The block SHALL have port cfg_we, input, 1 bit: one-cycle write strobe for cfg_c, cfg_d and cfg_max.
REQ-012 The block SHALL have ports cfg_c, cfg_d and cfg_max, input, CNT_W bits each: new gain/limit values.
REQ-013 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a configuration write is rejected.
REQ-014 The block SHALL have ports add_pulse and sub_pulse, output, 1 bit each: DCO correction requests.
REQ-015 The block SHALL have ports lead_cnt and lag_cnt, output, CNT_W bits each: counter observation (MODE 1: lead_cnt carries the signed walk value, lag_cnt = 0).
REQ-016 The block SHALL have port sat, output, 1 bit: any counter currently at +MAX or -MAX.

Function
REQ-017 lead and lag both 1 in the same cycle SHALL be treated as both 0 (cancel) in both modes.
REQ-018 MODE 0: each channel SHALL compute next = cnt + (in ? C : 0) - (cnt >= D ? D : 0), in CNT_W+2-bit signed arithmetic.
REQ-019 MODE 0: the next counter value SHALL be clamped to the range 0..MAX.
REQ-020 MODE 0: add_pulse SHALL equal registered (lead counter >= D), i.e. one cycle after the counter reaches D; sub_pulse SHALL be the same for the lag counter.
REQ-021 MODE 1: a single signed counter SHALL add C on effective lead and subtract C on effective lag.
REQ-022 MODE 1: on reaching >= +MAX the counter SHALL emit add_pulse for one cycle and load 0 on the same edge; on <= -MAX it SHALL emit sub_pulse and load 0.
REQ-023 add_pulse and sub_pulse SHALL never both be 1; if both would assert, both SHALL be forced to 0.
REQ-024 en = 0 SHALL hold all counters and force add_pulse = sub_pulse = 0; configuration writes SHALL still be accepted.
REQ-025 On cfg_we with cfg_d != 0, cfg_c != 0 and 0 < cfg_max < 2^(CNT_W-1), C, D and MAX SHALL update on that clock edge.
REQ-026 On a configuration update, counters SHALL be clamped to the new MAX on the same edge.
REQ-027 On cfg_we with any out-of-range field, the whole write SHALL be ignored and cfg_err SHALL pulse for one cycle.
REQ-028 When a configuration write and count activity occur in the same cycle, counting that cycle SHALL use the old C, D and MAX.

Reset
REQ-029 While rst_n = 0, all counters SHALL be 0, add_pulse, sub_pulse, sat and cfg_err SHALL be 0, and C, D, MAX SHALL take C_DEF, D_DEF, MAX_DEF.
REQ-030 Reset asserted mid-operation SHALL clear all state immediately; the first count SHALL occur on the first clk edge after rst_n rises.

Structure
REQ-031 Package lead_lag_pkg SHALL hold the mode encoding constants and the default C/D/MAX constants.
REQ-032 Sub-module lead_lag_chan (one leaky saturating channel) SHALL be instantiated twice for MODE 0; MODE 1 logic SHALL live in the top level.

Verification
REQ-033 MODE 0, defaults, lead = 1 for 3 cycles then 0 -> lead_cnt goes 1, 1, 1, then 0; add_pulse = 1 from one cycle after lead_cnt first reaches 1 until one cycle after it returns to 0.
REQ-034 MODE 0, C = 5, D = 1, MAX = 20, lead held high -> lead_cnt reaches 20 and holds; sat = 1; no wrap.
REQ-035 MODE 1, C = 1, MAX = 4, lead high for 4 cycles -> add_pulse exactly one cycle; lead_cnt returns to 0.
REQ-036 lead = lag = 1 for 10 cycles -> counters unchanged; no pulses.
REQ-037 cfg_we with cfg_d = 0 -> cfg_err pulses for one cycle; C, D, MAX unchanged. Valid write with cfg_max = 3 while a counter is at 10 -> that counter reads 3 on the next cycle.
REQ-038 rst_n asserted while add_pulse = 1 and counters are nonzero -> all outputs 0 immediately; defaults restored.
